clock_display_driver: RTL and testbench

- Downstream consumer of the 50 MHz clock generator's divided outputs clk_1hz and clk_1k.
- Keeps an HH:MM:SS time-of-day count advanced by clk_1hz.
- Drives a 6-digit multiplexed common-anode seven-segment display scanned at clk_1k.
- All logic runs in the Clk_50M domain; clk_1hz and clk_1k are treated as asynchronous level inputs and converted to single-cycle ticks.

---
 rtl/clock_display_driver.sv | 168 ++++++++++++++++
 tb/tb_clock_display_driver.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_display_driver.sv
// Time-of-day clock with a 6-digit multiplexed common-anode seven-segment driver.
// clk_1hz advances an HH:MM:SS BCD count and clk_1k steps the digit scan.
// Both inputs are asynchronous to Clk_50M and are turned into one-cycle ticks.
module clock_display_driver #(
    parameter int         HR_MAX  = 23,
    parameter logic [5:0] DP_MASK = 6'b010100
) (
    input  logic       Clk_50M,
    input  logic       Rst_n,
    input  logic       clk_1hz,
    input  logic       clk_1k,
    input  logic       en,
    input  logic       clr,
    output logic [5:0] sel,
    output logic [7:0] seg,
    output logic       day_tick
);

    localparam logic [3:0] HR_T_MAX = 4'(HR_MAX / 10);
    localparam logic [3:0] HR_U_MAX = 4'(HR_MAX % 10);

    // Bit 0 is the first synchroniser stage, bit 2 the edge-detect history.
    logic [2:0] hz_sync;
    logic [2:0] k_sync;
    logic       sec_tick;
    logic       scan_tick;

    logic [3:0] sec_u, sec_t, min_u, min_t, hr_u, hr_t;
    logic [2:0] idx;
    logic [3:0] digit;
    logic [6:0] seg7;
    logic [7:0] dp_bits;

    logic sec_u_max, sec_t_max, min_u_max, min_t_max, hr_max_hit, day_wrap;

    // Synchronise both slow clocks and keep one extra stage for rise detection.
    always_ff @(posedge Clk_50M or negedge Rst_n) begin
        if (!Rst_n) begin
            hz_sync <= 3'b000;
            k_sync  <= 3'b000;
        end else begin
            hz_sync <= {hz_sync[1:0], clk_1hz};
            k_sync  <= {k_sync[1:0], clk_1k};
        end
    end

    assign sec_tick  = hz_sync[1] & ~hz_sync[2];
    assign scan_tick = k_sync[1] & ~k_sync[2];

    assign sec_u_max  = (sec_u == 4'd9);
    assign sec_t_max  = (sec_t == 4'd5);
    assign min_u_max  = (min_u == 4'd9);
    assign min_t_max  = (min_t == 4'd5);
    assign hr_max_hit = (hr_t == HR_T_MAX) && (hr_u == HR_U_MAX);
    assign day_wrap   = sec_u_max && sec_t_max && min_u_max && min_t_max && hr_max_hit;

    // Time counter: clear wins over a tick; disabled ticks are simply dropped.
    always_ff @(posedge Clk_50M or negedge Rst_n) begin
        if (!Rst_n) begin
            sec_u    <= 4'd0;
            sec_t    <= 4'd0;
            min_u    <= 4'd0;
            min_t    <= 4'd0;
            hr_u     <= 4'd0;
            hr_t     <= 4'd0;
            day_tick <= 1'b0;
        end else if (clr) begin
            sec_u    <= 4'd0;
            sec_t    <= 4'd0;
            min_u    <= 4'd0;
            min_t    <= 4'd0;
            hr_u     <= 4'd0;
            hr_t     <= 4'd0;
            day_tick <= 1'b0;
        end else if (sec_tick && en) begin
            day_tick <= day_wrap;
            if (!sec_u_max) begin
                sec_u <= sec_u + 4'd1;
            end else begin
                sec_u <= 4'd0;
                if (!sec_t_max) begin
                    sec_t <= sec_t + 4'd1;
                end else begin
                    sec_t <= 4'd0;
                    if (!min_u_max) begin
                        min_u <= min_u + 4'd1;
                    end else begin
                        min_u <= 4'd0;
                        if (!min_t_max) begin
                            min_t <= min_t + 4'd1;
                        end else begin
                            min_t <= 4'd0;
                            if (hr_max_hit) begin
                                hr_u <= 4'd0;
                                hr_t <= 4'd0;
                            end else if (hr_u == 4'd9) begin
                                hr_u <= 4'd0;
                                hr_t <= hr_t + 4'd1;
                            end else begin
                                hr_u <= hr_u + 4'd1;
                            end
                        end
                    end
                end
            end
        end else begin
            day_tick <= 1'b0;
        end
    end

    // Scan index walks 0..5; an illegal 6/7 is pulled back to 0 on the next edge.
    always_ff @(posedge Clk_50M or negedge Rst_n) begin
        if (!Rst_n) begin
            idx <= 3'd0;
        end else if (idx > 3'd5) begin
            idx <= 3'd0;
        end else if (scan_tick) begin
            idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end
    end

    // Pick the BCD digit shown at the current scan position.
    always_comb begin
        digit = sec_u;
        case (idx)
            3'd0:    digit = sec_u;
            3'd1:    digit = sec_t;
            3'd2:    digit = min_u;
            3'd3:    digit = min_t;
            3'd4:    digit = hr_u;
            3'd5:    digit = hr_t;
            default: digit = 4'd0;
        endcase
    end

    // Active-low g..a pattern for one BCD digit; non-decimal codes blank.
    always_comb begin
        seg7 = 7'h7F;
        case (digit)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    end

    // Padded so an illegal index reads an unlit decimal point.
    assign dp_bits = {2'b00, DP_MASK};

    // Register the display drive so the pins never glitch; reset blanks them.
    always_ff @(posedge Clk_50M or negedge Rst_n) begin
        if (!Rst_n) begin
            sel <= 6'h3F;
            seg <= 8'hFF;
        end else begin
            sel <= ~(6'd1 << idx);
            seg <= {~dp_bits[idx], seg7};
        end
    end

endmodule

// File: tb/tb_clock_display_driver.sv
// Bench for clock_display_driver: a 24-hour instance and a 12-hour instance
// share all inputs; a seconds-of-day model predicts what each should display.
module tb_clock_display_driver;

    logic       Clk_50M = 1'b0;
    logic       Rst_n   = 1'b0;
    logic       clk_1hz = 1'b0;
    logic       clk_1k  = 1'b0;
    logic       en      = 1'b0;
    logic       clr     = 1'b0;
    logic [5:0] sel, sel11;
    logic [7:0] seg, seg11;
    logic       day_tick, day11;

    clock_display_driver #(.HR_MAX(23), .DP_MASK(6'b010100)) dut (
        .Clk_50M(Clk_50M), .Rst_n(Rst_n), .clk_1hz(clk_1hz), .clk_1k(clk_1k),
        .en(en), .clr(clr), .sel(sel), .seg(seg), .day_tick(day_tick)
    );

    clock_display_driver #(.HR_MAX(11), .DP_MASK(6'b010100)) dut11 (
        .Clk_50M(Clk_50M), .Rst_n(Rst_n), .clk_1hz(clk_1hz), .clk_1k(clk_1k),
        .en(en), .clr(clr), .sel(sel11), .seg(seg11), .day_tick(day11)
    );

    always #10 Clk_50M = ~Clk_50M;

    int errs   = 0;
    int checks = 0;
    logic [13:0] sb[$];

    // model: seconds of day per instance and the shared scan index
    int t_m   = 0;
    int t_e   = 0;
    int idx_m = 0;

    logic [7:0] dt_h0, dt_h1;
    logic [5:0] sel_h3, sel_h2;

    // force sources for preloading the digit registers
    logic [3:0] pm0, pm1, pm2, pm3, pm4, pm5;
    logic [3:0] pe0, pe1, pe2, pe3, pe4, pe5;

    task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] lut(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic int digit_of(input int t, input int i);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        case (i)
            0: return s % 10;
            1: return s / 10;
            2: return m % 10;
            3: return m / 10;
            4: return h % 10;
            default: return h / 10;
        endcase
    endfunction

    function automatic logic [13:0] exp_out(input int t, input int i);
        logic [5:0] s;
        logic [5:0] dpm;
        s   = 6'h3F;
        dpm = 6'b010100;
        s[i] = 1'b0;
        return {s, ~dpm[i], lut(digit_of(t, i))};
    endfunction

    // One rise/fall of clk_1k or clk_1hz, 8 cycles; called at a negedge.
    // Sample k is taken after posedge N+k, where N is the edge that first sees the rise.
    task pulse(input bit hz);
        for (int k = 0; k < 8; k++) begin
            if (k == 0) begin
                if (hz) clk_1hz = 1'b1; else clk_1k = 1'b1;
            end
            if (k == 4) begin
                clk_1hz = 1'b0;
                clk_1k  = 1'b0;
            end
            @(negedge Clk_50M);
            dt_h0[k] = day_tick;
            dt_h1[k] = day11;
            if (k == 2) sel_h2 = sel;
            if (k == 3) sel_h3 = sel;
        end
    endtask

    task sec_pulse();
        pulse(1'b1);
        if (en) begin
            t_m = (t_m + 1) % (24 * 3600);
            t_e = (t_e + 1) % (12 * 3600);
        end
    endtask

    task scan_step();
        pulse(1'b0);
        idx_m = (idx_m + 1) % 6;
    endtask

    // Walk one full frame, comparing each digit position on both instances.
    task frame();
        int j;
        j = idx_m;
        for (int i = 0; i < 6; i++) begin
            sb.push_back(exp_out(t_m, j));
            sb.push_back(exp_out(t_e, j));
            j = (j + 1) % 6;
        end
        for (int i = 0; i < 6; i++) begin
            chk("frame_hr23", {sel, seg}, sb.pop_front());
            chk("frame_hr11", {sel11, seg11}, sb.pop_front());
            scan_step();
        end
    endtask

    // Load both clocks with arbitrary times; called at a negedge.
    task preload(input int tm, input int te);
        pm0 = 4'(digit_of(tm, 0)); pm1 = 4'(digit_of(tm, 1)); pm2 = 4'(digit_of(tm, 2));
        pm3 = 4'(digit_of(tm, 3)); pm4 = 4'(digit_of(tm, 4)); pm5 = 4'(digit_of(tm, 5));
        pe0 = 4'(digit_of(te, 0)); pe1 = 4'(digit_of(te, 1)); pe2 = 4'(digit_of(te, 2));
        pe3 = 4'(digit_of(te, 3)); pe4 = 4'(digit_of(te, 4)); pe5 = 4'(digit_of(te, 5));
        force dut.sec_u = pm0; force dut.sec_t = pm1; force dut.min_u = pm2;
        force dut.min_t = pm3; force dut.hr_u  = pm4; force dut.hr_t  = pm5;
        force dut11.sec_u = pe0; force dut11.sec_t = pe1; force dut11.min_u = pe2;
        force dut11.min_t = pe3; force dut11.hr_u  = pe4; force dut11.hr_t  = pe5;
        @(negedge Clk_50M);
        release dut.sec_u; release dut.sec_t; release dut.min_u;
        release dut.min_t; release dut.hr_u;  release dut.hr_t;
        release dut11.sec_u; release dut11.sec_t; release dut11.min_u;
        release dut11.min_t; release dut11.hr_u;  release dut11.hr_t;
        @(negedge Clk_50M);
        t_m = tm;
        t_e = te;
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge Clk_50M);
        chk("rst_sel", sel, 6'h3F);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_day", day_tick, 1'b0);
        Rst_n = 1'b1;
        @(negedge Clk_50M);
        chk("first_sel", sel, 6'b111110);
        chk("first_seg", seg, 8'hC0);

        // scan latency and wrap of the index
        scan_step();
        chk("scan_sel_n2", sel_h2, 6'b111110);
        chk("scan_sel_n3", sel_h3, 6'b111101);
        repeat (5) scan_step();
        chk("scan_wrap", sel, 6'b111110);
        frame();

        // one minute of seconds
        en = 1'b1;
        repeat (60) sec_pulse();
        chk("min_idx2_seg", 32'(exp_out(t_m, 2)), {18'd0, 6'b111011, 8'h79});
        frame();

        // disabled ticks are dropped, scanning still rotates
        en = 1'b0;
        repeat (5) sec_pulse();
        frame();
        en = 1'b1;
        sec_pulse();
        frame();

        // day wrap on both hour limits, day_tick exactly the cycle after the update edge
        preload(86399, 43199);
        frame();
        sec_pulse();
        chk("day_tick_hr23", dt_h0, 8'b00000100);
        chk("day_tick_hr11", dt_h1, 8'b00000100);
        frame();

        // clear coincident with a wrapping tick: zero time, no day_tick
        preload(86399, 43199);
        for (int k = 0; k < 8; k++) begin
            if (k == 0) clk_1hz = 1'b1;
            if (k == 2) clr = 1'b1;
            if (k == 3) clr = 1'b0;
            if (k == 4) clk_1hz = 1'b0;
            @(negedge Clk_50M);
            dt_h0[k] = day_tick;
            dt_h1[k] = day11;
        end
        t_m = 0;
        t_e = 0;
        chk("clr_day_hr23", dt_h0, 8'h00);
        chk("clr_day_hr11", dt_h1, 8'h00);
        frame();

        // clear alone with counting disabled
        preload(3723, 3723);
        en  = 1'b0;
        clr = 1'b1;
        @(negedge Clk_50M);
        clr = 1'b0;
        @(negedge Clk_50M);
        t_m = 0;
        t_e = 0;
        frame();
        en = 1'b1;

        // asynchronous reset mid-scan at index 4 showing 12:34:56
        preload(45296, 41696);
        while (idx_m != 4) scan_step();
        chk("pre_rst_hr23", {sel, seg}, exp_out(t_m, 4));
        #3 Rst_n = 1'b0;
        #1;
        chk("async_sel", sel, 6'h3F);
        chk("async_seg", seg, 8'hFF);
        chk("async_day", day_tick, 1'b0);
        @(negedge Clk_50M);
        Rst_n = 1'b1;
        t_m   = 0;
        t_e   = 0;
        idx_m = 0;
        @(negedge Clk_50M);
        chk("post_rst_sel", sel, 6'b111110);
        chk("post_rst_seg", seg, 8'hC0);
        frame();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
